// File: rtl/fp754_pkg.sv
// Shared binary32 constants, normaliser state encoding, flag bit positions
// and a field-packing helper for the add/sub post-ALU stage.
package fp754_pkg;

   localparam int FP_EXP_W   = 8;
   localparam int FP_FRAC_W  = 23;
   localparam int FP_BIAS    = 127;
   localparam int FP_EXP_INF = 255;

   // out_flags bit positions: {ovf, uflow, zero}
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_UFLOW = 1;
   localparam int FLAG_OVF   = 2;
   localparam int FLAG_W     = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } fp_state_e;

   function automatic logic [31:0] fp_pack(input logic                 sign,
                                           input logic [FP_EXP_W-1:0]  exp,
                                           input logic [FP_FRAC_W-1:0] frac);
      return {sign, exp, frac};
   endfunction

endpackage

// File: rtl/fp_normalize_round_if.sv
// Operand/result bus of the normalise-and-round stage. Both sides are valid/ready:
// a transfer happens on a rising clk edge where valid && ready; valid holds its payload until then.
interface fp_normalize_round_if #(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
);

   logic              in_valid;
   logic              in_ready;
   logic [MANT_W:0]   in_mant;
   logic [EXP_W-1:0]  in_exp;
   logic              in_sign;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_result;
   logic [2:0]        out_flags;

   modport master (
      output in_valid, in_mant, in_exp, in_sign, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_mant, in_exp, in_sign, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );

endinterface

// File: rtl/fp_normalize_round_fa_24.sv
// Carry-propagate adder used as the round-to-nearest-even incrementer
// (b tied to zero, cin carries the round bit).
module fa_24 #(
   parameter int W = 24
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/fp_normalize_round.sv
// Iterative normalise + RNE round + binary32 pack, one operation in flight.
// Optional build macro FP_NORM_DENORM_EN: tiny results packed as denormals instead of signed zero.
module fp_normalize_round
   import fp754_pkg::*;
#(
   parameter int MANT_W = 24,
   parameter int EXP_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fp_normalize_round_if.slave  bus,
   output fp_state_e            state_dbg
);

   // Signed working exponent, two bits wider so overflow/underflow never wrap.
   localparam int IEXP_W = EXP_W + 2;
   typedef logic signed [IEXP_W-1:0] iexp_t;
   localparam iexp_t EXP_ONE   = iexp_t'(1);
   localparam iexp_t EXP_TWO   = iexp_t'(2);
   localparam iexp_t EXP_INF_I = iexp_t'(FP_EXP_INF);

   fp_state_e           state, state_n;
   logic [MANT_W:0]     mant_q, mant_n;
   iexp_t               exp_q, exp_n;
   logic                sign_q, sign_n;
   logic [31:0]         result_q, result_n;
   logic [FLAG_W-1:0]   flags_q, flags_n;

   iexp_t               in_exp_i;
   logic                rnd_bit;
   logic [MANT_W-1:0]   fa_sum;
   logic                fa_cout;
   logic [MANT_W-1:0]   carry_mant;
   logic [MANT_W-1:0]   norm_mant;
   iexp_t               norm_exp;

   assign in_exp_i = (bus.in_exp == '0) ? EXP_ONE : $signed({2'b00, bus.in_exp});

   // Right shift drops one bit; with a single dropped bit every set bit is a tie, so round to even.
   assign rnd_bit = mant_q[0] & mant_q[1];

   fa_24 #(.W(MANT_W)) u_fa_24 (
      .a    (mant_q[MANT_W:1]),
      .b    ('0),
      .cin  (rnd_bit),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // A rounding carry makes the value exactly 2^MANT_W: renormalise once more, no further rounding.
   assign carry_mant = fa_cout ? {fa_cout, fa_sum[MANT_W-1:1]} : fa_sum;

   always_comb begin
      norm_mant = mant_q[MANT_W-1:0];
      norm_exp  = exp_q;
      if (mant_q[MANT_W]) begin
         norm_mant = carry_mant;
         norm_exp  = exp_q + (fa_cout ? EXP_TWO : EXP_ONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         mant_q   <= '0;
         exp_q    <= '0;
         sign_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state    <= state_n;
         mant_q   <= mant_n;
         exp_q    <= exp_n;
         sign_q   <= sign_n;
         result_q <= result_n;
         flags_q  <= flags_n;
      end
   end

   always_comb begin
      state_n  = state;
      mant_n   = mant_q;
      exp_n    = exp_q;
      sign_n   = sign_q;
      result_n = result_q;
      flags_n  = flags_q;
      case (state)
         ST_IDLE: begin
            if (bus.in_valid) begin
               mant_n  = bus.in_mant;
               exp_n   = in_exp_i;
               sign_n  = bus.in_sign;
               state_n = ST_NORM;
            end
         end
         ST_NORM: begin
            if (mant_q == '0) begin
               result_n           = '0;
               flags_n            = '0;
               flags_n[FLAG_ZERO] = 1'b1;
               state_n            = ST_DONE;
            end else if (norm_mant[MANT_W-1]) begin
               flags_n = '0;
               if (norm_exp >= EXP_INF_I) begin
                  result_n          = fp_pack(sign_q, '1, '0);
                  flags_n[FLAG_OVF] = 1'b1;
               end else begin
                  result_n = fp_pack(sign_q, norm_exp[FP_EXP_W-1:0], norm_mant[FP_FRAC_W-1:0]);
               end
               state_n = ST_DONE;
            end else if (exp_q > EXP_ONE) begin
               mant_n = {mant_q[MANT_W-1:0], 1'b0};
               exp_n  = exp_q - EXP_ONE;
            end else begin
               flags_n             = '0;
               flags_n[FLAG_UFLOW] = 1'b1;
`ifdef FP_NORM_DENORM_EN
               result_n = fp_pack(sign_q, '0, mant_q[FP_FRAC_W-1:0]);
`else
               result_n = {sign_q, 31'b0};
`endif
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign bus.in_ready   = (state == ST_IDLE);
   assign bus.out_valid  = (state == ST_DONE);
   assign bus.out_result = result_q;
   assign bus.out_flags  = flags_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed-vector bench for fp_normalize_round: result, flags, latency, hold-while-stalled
// and asynchronous reset in the middle of normalisation.
module tb_fp_normalize_round;
   import fp754_pkg::*;

   typedef struct {
      logic [24:0] mant;
      logic [7:0]  exp;
      logic        sign;
      logic [31:0] res;
      logic [2:0]  flags;
      int          k;
      int          hold;
   } vec_t;

   logic      clk;
   logic      rst_n;
   fp_state_e state_dbg;
   int        checks;
   int        errors;
   logic [34:0] exp_q[$];
   vec_t      vecs[13];

   fp_normalize_round_if #(.MANT_W(24), .EXP_W(8)) bus ();

   fp_normalize_round #(.MANT_W(24), .EXP_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // driver: issue one operation, measure latency, compare, optionally stall, then retire
   task automatic run_op(input vec_t v, input string tag);
      int          cyc;
      logic [34:0] exp_word;
      @(negedge clk);
      check({tag, "_in_ready"}, bus.in_ready, 1'b1);
      bus.in_mant  = v.mant;
      bus.in_exp   = v.exp;
      bus.in_sign  = v.sign;
      bus.in_valid = 1'b1;
      exp_q.push_back({v.flags, v.res});
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      cyc = 1;
      while (cyc < 60) begin
         @(negedge clk);
         if (bus.out_valid) break;
         @(posedge clk);
         #1;
         cyc++;
      end
      check({tag, "_latency"}, cyc, 2 + v.k);
      exp_word = exp_q.pop_front();
      check({tag, "_result"}, bus.out_result, exp_word[31:0]);
      check({tag, "_flags"}, bus.out_flags, exp_word[34:32]);
      check({tag, "_busy_in_ready"}, bus.in_ready, 1'b0);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, bus.out_valid, 1'b1);
         check({tag, "_hold_result"}, bus.out_result, exp_word[31:0]);
         check({tag, "_hold_flags"}, bus.out_flags, exp_word[34:32]);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      check({tag, "_retire_valid"}, bus.out_valid, 1'b0);
      check({tag, "_retire_in_ready"}, bus.in_ready, 1'b1);
   endtask

   initial begin
      logic [31:0] tiny3_res;
      logic [31:0] tiny1_res;
`ifdef FP_NORM_DENORM_EN
      tiny3_res = 32'h8000_0004;
      tiny1_res = 32'h0040_0000;
`else
      tiny3_res = 32'h8000_0000;
      tiny1_res = 32'h0000_0000;
`endif
      //          mant          exp     sign  result          flags   k   hold
      vecs[0]  = '{25'h0800000, 8'd127, 1'b0, 32'h3F80_0000, 3'b000, 0,  3};
      vecs[1]  = '{25'h1000003, 8'd127, 1'b0, 32'h4000_0002, 3'b000, 0,  0};
      vecs[2]  = '{25'h1000001, 8'd127, 1'b0, 32'h4000_0000, 3'b000, 0,  0};
      vecs[3]  = '{25'h0000001, 8'd127, 1'b0, 32'h3400_0000, 3'b000, 23, 0};
      vecs[4]  = '{25'h0000000, 8'd127, 1'b1, 32'h0000_0000, 3'b001, 0,  1};
      vecs[5]  = '{25'h1000000, 8'd254, 1'b0, 32'h7F80_0000, 3'b100, 0,  0};
      vecs[6]  = '{25'h0000001, 8'd3,   1'b1, tiny3_res,     3'b010, 2,  0};
      vecs[7]  = '{25'h1FFFFFF, 8'd127, 1'b0, 32'h4080_0000, 3'b000, 0,  0};
      vecs[8]  = '{25'h0C00000, 8'd130, 1'b1, 32'hC140_0000, 3'b000, 0,  0};
      vecs[9]  = '{25'h0800000, 8'd0,   1'b0, 32'h0080_0000, 3'b000, 0,  0};
      vecs[10] = '{25'h1FFFFFF, 8'd253, 1'b1, 32'hFF80_0000, 3'b100, 0,  0};
      vecs[11] = '{25'h0400000, 8'd127, 1'b0, 32'h3F00_0000, 3'b000, 1,  0};
      vecs[12] = '{25'h0400000, 8'd1,   1'b0, tiny1_res,     3'b010, 0,  0};

      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_mant   = '0;
      bus.in_exp    = '0;
      bus.in_sign   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_result", bus.out_result, 32'h0);
      check("rst_flags", bus.out_flags, 3'b000);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // asynchronous reset while the 23-shift operation is still normalising
      @(negedge clk);
      bus.in_mant  = 25'h0000001;
      bus.in_exp   = 8'd127;
      bus.in_sign  = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("midrst_pre_state", 64'(state_dbg), 64'(ST_NORM));
      check("midrst_pre_in_ready", bus.in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 1'b0);
      check("midrst_state", 64'(state_dbg), 64'(ST_IDLE));
      check("midrst_result", bus.out_result, 32'h0);
      check("midrst_flags", bus.out_flags, 3'b000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_release_in_ready", bus.in_ready, 1'b1);
      repeat (25) @(negedge clk);
      check("midrst_no_stale_valid", bus.out_valid, 1'b0);
      run_op(vecs[0], "post_rst");
      run_op(vecs[6], "post_rst_tiny");

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
